// File: rtl/mult_div.sv
// mult_div: iterative signed multiply / restoring divide unit writing HI/LO,
// one bit per cycle over magnitudes with sign fix-up at the end.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdControl,
    input  logic             mdOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             zeroDiv
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic               op;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
    // mult: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    // div: acc = {remainder, remaining dividend bits / quotient bits}, shifted left each step
    assign r_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign trial = r_sh - {1'b0, m};
    assign step  = op ? {trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0], acc[WIDTH-2:0], ~trial[WIDTH]}
                      : {sum, acc[WIDTH-1:1]};
    assign prod  = neg_q ? -acc : acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
            m       <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            zeroDiv <= 1'b0;
        end else begin
            done    <= 1'b0;
            zeroDiv <= 1'b0;
            case (state)
                IDLE: if (mdControl) begin
                    if (mdOp && b == '0) begin
                        zeroDiv <= 1'b1;
                    end else begin
                        op    <= mdOp;
                        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r <= a[WIDTH-1];
                        m     <= mdOp ? abs_b : abs_a;
                        acc   <= {{WIDTH{1'b0}}, mdOp ? abs_a : abs_b};
                        cnt   <= CW'(WIDTH-1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (op) begin
                        lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div.
module tb_mult_div;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdControl = 1'b0;
    logic        mdOp = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        zeroDiv;
    int total = 0;
    int bad = 0;

    mult_div dut (
        .clk(clk), .reset(reset), .mdControl(mdControl), .mdOp(mdOp),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .zeroDiv(zeroDiv)
    );

    always #5 clk = ~clk;

    // returns #1 after the start edge, with operands scrambled to prove they were latched
    task automatic start_op(input logic op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        mdControl = 1'b1;
        mdOp = op;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        mdControl = 1'b0;
        mdOp = ~op;
        a = $urandom;
        b = 32'd0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output int zd_cnt);
        lat = 0;
        busy_cnt = 0;
        zd_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (zeroDiv) zd_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({hi, lo, busy, done, zeroDiv} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b zd=%b want all zero", hi, lo, busy, done, zeroDiv);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int lat, bc, zc;
        start_op(1'b0, 32'd7, 32'hFFFFFFFD);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_start: got %b want 1", busy); end
        wait_done(lat, bc, zc);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
        total++;
        if (bc !== 33) begin bad++; $display("FAIL mult_busy_len: got %0d want 33", bc); end
        total++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
        start_op(1'b0, 32'h80000000, 32'h80000000);
        wait_done(lat, bc, zc);
        total++;
        if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_min_sq: got %h_%h want 40000000_00000000", hi, lo); end
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc, zc);
        total++;
        if ({hi, lo} !== 64'h00000000_00000001) begin bad++; $display("FAIL mult_m1_sq: got %h_%h want 00000000_00000001", hi, lo); end
    endtask

    task automatic test_div();
        int lat, bc, zc;
        start_op(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bc, zc);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
        total++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_-7/2: got hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
        start_op(1'b1, 32'd100, 32'd7);
        wait_done(lat, bc, zc);
        total++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL div_100/7: got hi=%h lo=%h want 2 14", hi, lo); end
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bc, zc);
        total++;
        if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", hi, lo); end
        total++;
        if (zc !== 0) begin bad++; $display("FAIL div_overflow_zd: got %0d zeroDiv pulses want 0", zc); end
    endtask

    task automatic test_div_zero();
        int lat, bc, zc;
        start_op(1'b0, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, bc, zc);
        start_op(1'b1, 32'd5, 32'd0);
        total++;
        if ({zeroDiv, busy, done} !== 3'b100) begin bad++; $display("FAIL dz_pulse: got zd=%b busy=%b done=%b want 1 0 0", zeroDiv, busy, done); end
        @(posedge clk);
        #1;
        total++;
        if ({zeroDiv, busy, done} !== 3'b000) begin bad++; $display("FAIL dz_after: got zd=%b busy=%b done=%b want 0 0 0", zeroDiv, busy, done); end
        total++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL dz_hilo_kept: got %h_%h want ffffffff_ffffffeb", hi, lo); end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, zc;
        @(negedge clk);
        mdControl = 1'b1;
        mdOp = 1'b0;
        a = 32'd3;
        b = 32'd5;
        @(posedge clk);
        #1;
        mdOp = 1'b1;
        a = 32'd100;
        b = 32'd7;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        mdControl = 1'b0;
        total++;
        if (lat !== 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        total++;
        if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL ignore_result: got %h_%h want 0_f", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, zc;
        start_op(1'b0, 32'd6, 32'd7);
        wait_done(lat, bc, zc);
        total++;
        if (lo !== 32'd42) begin bad++; $display("FAIL b2b_first: got lo=%h want 2a", lo); end
        start_op(1'b1, 32'd100, 32'd7);
        total++;
        if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); end
        wait_done(lat, bc, zc);
        total++;
        if (lat !== 33 || {hi, lo} !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want 33 2 14", lat, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, zc, dn;
        start_op(1'b0, 32'h00012345, 32'h00006789);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({hi, lo, busy} !== 65'd0) begin bad++; $display("FAIL abort_clear: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy); end
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL abort_no_done: got %0d done pulses want 0", dn); end
        start_op(1'b1, 32'd9, 32'd3);
        wait_done(lat, bc, zc);
        total++;
        if ({hi, lo} !== {32'd0, 32'd3}) begin bad++; $display("FAIL abort_then_div: got hi=%h lo=%h want 0 3", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
